key_debouncer: RTL

//  Multi-channel push-button debouncer driven by the slow sample clock from the

---
 rtl/key_debouncer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//
// Multi-channel push-button debouncer. Raw keys and the slow sample clock
// from the debouncer clock divider are synchronised into clk. Each rising
// edge of the synchronised sample clock produces a one-clk tick, and every
// channel's state machine advances only on that tick. Each channel drives a
// clean level and one-clk press / release / long-press pulses.
//
// Parameters
//   N_KEYS          number of independent key channels
//   STABLE_SAMPLES  consecutive differing samples needed to flip a level (>=1)
//   LONG_SAMPLES    held samples after a press before key_long fires
//                   (must be > STABLE_SAMPLES)
//   ACTIVE_LOW      1: a raw key reads 0 when pressed (inverted after sync)
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   asynchronous reset, active low
//   sclk_i       in   slow sample clock, used as data only
//   key_raw      in   raw asynchronous button inputs
//   key_level    out  debounced level, 1 = pressed
//   key_press    out  1-clk pulse on debounced 0->1
//   key_release  out  1-clk pulse on debounced 1->0
//   key_long     out  1-clk pulse once per press after LONG_SAMPLES held samples
//
// Per-channel states
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | released; cnt counts consecutive pressed samples
//   HELD    | pressed; cnt counts released samples, hold counts held samples
//   LONG    | pressed and long pulse already issued; hold frozen
// -----------------------------------------------------------------------------
module key_debouncer #(
    parameter int N_KEYS         = 5,
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_SAMPLES   = 500,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_i,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam int CW = $clog2(LONG_SAMPLES + 1);

    // Thresholds are compared against the pre-increment count, so the
    // transition happens on the tick where the count would reach the limit.
    localparam logic [CW-1:0] STABLE_M1 = CW'(STABLE_SAMPLES - 1);
    localparam logic [CW-1:0] LONG_M1   = CW'(LONG_SAMPLES - 1);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_SAMPLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Synchronisers and tick generation
    // -------------------------------------------------------------------------
    logic [N_KEYS-1:0] r_key_s1;
    logic [N_KEYS-1:0] r_key_s2;
    logic              r_sclk_s1;
    logic              r_sclk_s2;
    logic              r_sclk_prev;
    logic              r_tick;
    logic [N_KEYS-1:0] w_sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_s1    <= '0;
            r_key_s2    <= '0;
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_key_s1    <= key_raw;
            r_key_s2    <= r_key_s1;
            r_sclk_s1   <= sclk_i;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_prev <= r_sclk_s2;
            // Rising edges only; a falling sample clock never samples.
            r_tick      <= r_sclk_s2 & ~r_sclk_prev;
        end
    end

    assign w_sample = (ACTIVE_LOW != 0) ? ~r_key_s2 : r_key_s2;

    // -------------------------------------------------------------------------
    // Channel state machines
    // -------------------------------------------------------------------------
    state_t            r_state    [N_KEYS];
    state_t            w_state_nxt[N_KEYS];
    logic [CW-1:0]     r_cnt      [N_KEYS];
    logic [CW-1:0]     w_cnt_nxt  [N_KEYS];
    logic [CW-1:0]     r_hold     [N_KEYS];
    logic [CW-1:0]     w_hold_nxt [N_KEYS];

    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] r_release;
    logic [N_KEYS-1:0] r_long;
    logic [N_KEYS-1:0] w_press_d;
    logic [N_KEYS-1:0] w_release_d;
    logic [N_KEYS-1:0] w_long_d;
    logic [N_KEYS-1:0] w_level;

    // State register (pulses registered alongside the state they belong to).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_hold[i]  <= '0;
            end
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_hold[i]  <= w_hold_nxt[i];
            end
            r_press   <= w_press_d;
            r_release <= w_release_d;
            r_long    <= w_long_d;
        end
    end

    // Next-state logic; everything holds between ticks.
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_hold_nxt[i]  = r_hold[i];

            if (r_tick) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_sample[i]) begin
                            if (r_cnt[i] == STABLE_M1) begin
                                w_state_nxt[i] = ST_HELD;
                                w_cnt_nxt[i]   = '0;
                                w_hold_nxt[i]  = '0;
                            end else begin
                                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                            end
                        end else begin
                            w_cnt_nxt[i] = '0;
                        end
                    end

                    ST_HELD, ST_LONG: begin
                        if (!w_sample[i]) begin
                            // Released samples: the release path is evaluated
                            // first, so it always beats a long-press on the
                            // same tick.
                            if (r_cnt[i] == STABLE_M1) begin
                                w_state_nxt[i] = ST_IDLE;
                                w_cnt_nxt[i]   = '0;
                                w_hold_nxt[i]  = '0;
                            end else begin
                                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                            end
                        end else begin
                            // Pressed samples clear the release run but keep
                            // hold accumulating across bounces.
                            w_cnt_nxt[i] = '0;
                            if (r_state[i] == ST_HELD) begin
                                if (r_hold[i] == LONG_M1) begin
                                    w_state_nxt[i] = ST_LONG;
                                    w_hold_nxt[i]  = LONG_SAT;
                                end else begin
                                    w_hold_nxt[i] = r_hold[i] + 1'b1;
                                end
                            end
                        end
                    end

                    default: begin
                        w_state_nxt[i] = ST_IDLE;
                        w_cnt_nxt[i]   = '0;
                        w_hold_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    // Output decode: pulses come from the transition being taken this tick,
    // level from the current registered state.
    always_comb begin
        w_press_d   = '0;
        w_release_d = '0;
        w_long_d    = '0;
        w_level     = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            w_level[i] = (r_state[i] != ST_IDLE);
            if (r_tick) begin
                w_press_d[i]   = (r_state[i] == ST_IDLE) &&
                                 (w_state_nxt[i] == ST_HELD);
                w_release_d[i] = (r_state[i] != ST_IDLE) &&
                                 (w_state_nxt[i] == ST_IDLE);
                w_long_d[i]    = (r_state[i] == ST_HELD) &&
                                 (w_state_nxt[i] == ST_LONG);
            end
        end
    end

    assign key_level   = w_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;

endmodule
